// File: rtl/hpi_xfer_ctrl.sv
// HPI transfer controller: turns one request into an ADDRESS-port write followed
// by a DATA-port read or write, with programmable setup/strobe/recovery timing.
module hpi_xfer_ctrl #(
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int RECOVER_CYC = 2
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] A_SETUP = 3'd1;
  localparam logic [2:0] A_STB   = 3'd2;
  localparam logic [2:0] A_REC   = 3'd3;
  localparam logic [2:0] D_SETUP = 3'd4;
  localparam logic [2:0] D_STB   = 3'd5;
  localparam logic [2:0] D_REC   = 3'd6;
  localparam logic [2:0] RESP    = 3'd7;

  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

  localparam logic [1:0] PORT_DATA = 2'b00;
  localparam logic [1:0] PORT_ADDR = 2'b10;

  logic [2:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q, we_nxt;
  logic [15:0] addr_q, addr_nxt;
  logic [15:0] wdata_q, wdata_nxt;
  logic        accept;
  logic        capture;
  logic        is_a, is_d;
  logic        cs_nxt, w_nxt, r_nxt;
  logic [1:0]  port_nxt;
  logic [15:0] data_nxt;

  // Next-state and counter; pins are then decoded from the next state so every
  // output comes straight from a flop yet lines up with its state.
  always_comb begin
    accept    = req_valid && (state == IDLE);
    state_nxt = state;
    cnt_nxt   = cnt - 4'd1;
    we_nxt    = accept ? req_we : we_q;
    addr_nxt  = accept ? req_addr : addr_q;
    wdata_nxt = accept ? req_wdata : wdata_q;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        if (accept) begin
          state_nxt = A_SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      A_SETUP: if (cnt == 4'd0) begin state_nxt = A_STB;   cnt_nxt = STROBE_LD;  end
      A_STB:   if (cnt == 4'd0) begin state_nxt = A_REC;   cnt_nxt = RECOVER_LD; end
      A_REC:   if (cnt == 4'd0) begin state_nxt = D_SETUP; cnt_nxt = SETUP_LD;   end
      D_SETUP: if (cnt == 4'd0) begin state_nxt = D_STB;   cnt_nxt = STROBE_LD;  end
      D_STB:   if (cnt == 4'd0) begin state_nxt = D_REC;   cnt_nxt = RECOVER_LD; end
      D_REC:   if (cnt == 4'd0) begin state_nxt = RESP;    cnt_nxt = 4'd0;       end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase

    is_a     = (state_nxt == A_SETUP) || (state_nxt == A_STB) || (state_nxt == A_REC);
    is_d     = (state_nxt == D_SETUP) || (state_nxt == D_STB) || (state_nxt == D_REC);
    cs_nxt   = !((state_nxt == A_SETUP) || (state_nxt == A_STB) ||
                 (state_nxt == D_SETUP) || (state_nxt == D_STB));
    w_nxt    = !((state_nxt == A_STB) || ((state_nxt == D_STB) && we_nxt));
    r_nxt    = !((state_nxt == D_STB) && !we_nxt);
    port_nxt = is_a ? PORT_ADDR : PORT_DATA;
    data_nxt = 16'h0000;
    if (is_a)
      data_nxt = addr_nxt;
    else if (is_d && we_nxt)
      data_nxt = wdata_nxt;

    // Pin interface data lags the read strobe by two registers, so sample last.
    capture = (state == D_STB) && (cnt == 4'd0) && !we_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 16'h0000;
      hpi_address  <= PORT_DATA;
      hpi_data_out <= 16'h0000;
      hpi_cs       <= 1'b1;
      hpi_w        <= 1'b1;
      hpi_r        <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      we_q         <= we_nxt;
      addr_q       <= addr_nxt;
      wdata_q      <= wdata_nxt;
      req_ready    <= (state_nxt == IDLE);
      rsp_valid    <= (state_nxt == RESP);
      if (capture)
        rsp_rdata  <= hpi_data_in;
      hpi_address  <= port_nxt;
      hpi_data_out <= data_nxt;
      hpi_cs       <= cs_nxt;
      hpi_w        <= w_nxt;
      hpi_r        <= r_nxt;
    end
  end

  assign busy = ~req_ready;

endmodule

// File: tb/tb_hpi_xfer_ctrl.sv
// Directed bench for hpi_xfer_ctrl: default-timing write/read, ignored and
// back-to-back requests, mid-transfer reset, and a non-default timing instance.
module tb_hpi_xfer_ctrl;

  localparam int S = 1;
  localparam int T = 4;
  localparam int R = 2;
  localparam int BASE = S + T + R;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        req_valid, req_valid2;
  logic        req_ready, req_ready_2;
  logic        req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_valid_2;
  logic [15:0] rsp_rdata, rsp_rdata_2;
  logic        busy, busy_2;
  logic [1:0]  hpi_address, hpi_address_2;
  logic [15:0] hpi_data_out, hpi_data_out_2;
  logic [15:0] hpi_data_in = 16'h0000;
  logic        hpi_r, hpi_w, hpi_cs;
  logic        hpi_r_2, hpi_w_2, hpi_cs_2;

  logic [15:0] rd_value = 16'h0000;
  logic [15:0] pipe1 = 16'h0000;
  bit          monitor_on = 1'b0;
  int          checkCount = 0;
  int          failCount = 0;

  always #5 Clk = ~Clk;

  hpi_xfer_ctrl dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .hpi_address(hpi_address), .hpi_data_out(hpi_data_out),
    .hpi_data_in(hpi_data_in),
    .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs)
  );

  hpi_xfer_ctrl #(.SETUP_CYC(2), .STROBE_CYC(3), .RECOVER_CYC(1)) dut2 (
    .Clk(Clk), .Reset_N(Reset_N),
    .req_valid(req_valid2), .req_ready(req_ready_2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_2), .rsp_rdata(rsp_rdata_2), .busy(busy_2),
    .hpi_address(hpi_address_2), .hpi_data_out(hpi_data_out_2),
    .hpi_data_in(hpi_data_in),
    .hpi_r(hpi_r_2), .hpi_w(hpi_w_2), .hpi_cs(hpi_cs_2)
  );

  // Pin interface model: two register stages between read strobe and data.
  always @(posedge Clk) begin
    pipe1       <= hpi_r ? 16'h0000 : rd_value;
    hpi_data_in <= pipe1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  always @(negedge Clk)
    if (monitor_on)
      checkOutput("rw_excl", {31'd0, ~hpi_r & ~hpi_w}, 32'd0);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a request so it is accepted at the next edge (edge 0).
  task automatic applyStimulus(input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
  endtask

  // Cycle c is the clock period ending at edge c; edge 0 accepted the request.
  task automatic checkCycle(input int c, input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rd_exp);
    logic e_cs, e_w, e_r, e_rsp, e_busy;
    e_cs   = !((c >= 1 && c <= S + T) || (c >= BASE + 1 && c <= BASE + S + T));
    e_w    = !((c >= S + 1 && c <= S + T) || (we && c >= BASE + S + 1 && c <= BASE + S + T));
    e_r    = !(!we && c >= BASE + S + 1 && c <= BASE + S + T);
    e_rsp  = (c == 2 * BASE + 1);
    e_busy = (c >= 1 && c <= 2 * BASE + 1);
    checkOutput($sformatf("c%0d_ctl", c),
                {26'd0, hpi_cs, hpi_w, hpi_r, rsp_valid, busy, req_ready},
                {26'd0, e_cs, e_w, e_r, e_rsp, e_busy, !e_busy});
    if (c >= 1 && c <= BASE)
      checkOutput($sformatf("c%0d_apin", c), {14'd0, hpi_address, hpi_data_out},
                  {14'd0, 2'b10, addr});
    else if (c > BASE && c <= 2 * BASE)
      checkOutput($sformatf("c%0d_dpin", c), {14'd0, hpi_address, hpi_data_out},
                  {14'd0, 2'b00, (we ? wdata : 16'h0000)});
    if (c == 2 * BASE + 1)
      checkOutput("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, rd_exp});
  endtask

  task automatic checkTxn(input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rd_exp);
    for (int c = 1; c <= 2 * BASE + 2; c++) begin
      @(negedge Clk);
      checkCycle(c, we, addr, wdata, rd_exp);
      tick();
    end
  endtask

  initial begin
    Reset_N    = 1'b0;
    req_valid  = 1'b1;
    req_valid2 = 1'b0;
    req_we     = 1'b1;
    req_addr   = 16'hDEAD;
    req_wdata  = 16'hBEEF;
    repeat (3) tick();
    @(negedge Clk);
    checkOutput("rst_ctl", {27'd0, hpi_cs, hpi_w, hpi_r, rsp_valid, busy},
                {27'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    checkOutput("rst_pins", {14'd0, hpi_address, hpi_data_out}, 32'd0);
    checkOutput("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    Reset_N   = 1'b1;
    req_valid = 1'b0;
    @(negedge Clk);
    checkOutput("no_accept_in_reset", {31'd0, busy}, 32'd0);
    tick();

    $display("[TB] default write");
    applyStimulus(1'b1, 16'h1234, 16'hBEEF);
    req_valid = 1'b0;
    checkTxn(1'b1, 16'h1234, 16'hBEEF, 16'h0000);

    $display("[TB] default read");
    rd_value = 16'hA5C3;
    applyStimulus(1'b0, 16'h0400, 16'h7777);
    req_valid = 1'b0;
    req_addr  = 16'hFFFF;
    checkTxn(1'b0, 16'h0400, 16'h7777, 16'hA5C3);

    $display("[TB] request while busy, then back-to-back");
    monitor_on = 1'b1;
    rd_value   = 16'h0F0F;
    applyStimulus(1'b1, 16'h1111, 16'h2222);
    req_we    = 1'b0;
    req_addr  = 16'h5555;
    req_wdata = 16'h6666;
    checkTxn(1'b1, 16'h1111, 16'h2222, 16'hA5C3);
    req_valid = 1'b0;
    checkTxn(1'b0, 16'h5555, 16'h6666, 16'h0F0F);
    monitor_on = 1'b0;

    $display("[TB] reset in cycle 10 of a write");
    applyStimulus(1'b1, 16'h3333, 16'h4444);
    req_valid = 1'b0;
    repeat (9) tick();
    Reset_N = 1'b0;
    tick();
    Reset_N = 1'b1;
    for (int c = 11; c <= 20; c++) begin
      @(negedge Clk);
      checkOutput($sformatf("abort_c%0d", c),
                  {28'd0, hpi_cs, hpi_w, hpi_r, rsp_valid | busy},
                  {28'd0, 1'b1, 1'b1, 1'b1, 1'b0});
      tick();
    end
    applyStimulus(1'b1, 16'h0042, 16'h00AA);
    req_valid = 1'b0;
    checkTxn(1'b1, 16'h0042, 16'h00AA, 16'h0000);

    $display("[TB] SETUP=2 STROBE=3 RECOVER=1 instance");
    req_valid2 = 1'b1;
    req_we     = 1'b1;
    req_addr   = 16'h0101;
    req_wdata  = 16'h0202;
    tick();
    req_valid2 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge Clk);
      checkOutput($sformatf("p2_c%0d_rsp", c), {31'd0, rsp_valid_2}, {31'd0, c == 13});
      tick();
    end
    @(negedge Clk);
    checkOutput("p2_idle", {31'd0, busy_2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/hpi_xfer_ctrl.md
HPI_XFER_CTRL -- requirements
Module: hpi_xfer_ctrl

Interface
REQ-001 The module SHALL have parameter SETUP_CYC, default 1, which sets the number of cycles chip select is held active before each strobe.
REQ-002 The module SHALL have parameter STROBE_CYC, default 4, which sets the number of cycles the read or write strobe is held active; legal range is 3..15.
REQ-003 The module SHALL have parameter RECOVER_CYC, default 2, which sets the number of cycles all strobes are held inactive after each phase.
REQ-004 The module SHALL have port Clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The module SHALL have port Reset_N, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port req_valid, input, 1 bit: a transaction request.
REQ-007 The module SHALL have port req_ready, output, 1 bit: the module can accept a request.
REQ-008 The module SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The module SHALL have port req_addr, input, 16 bits: the EZ-OTG memory address.
REQ-010 The module SHALL have port req_wdata, input, 16 bits: the write data.
REQ-011 The module SHALL have port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 The module SHALL have port rsp_rdata, output, 16 bits: the read data, valid when rsp_valid = 1.
REQ-013 The module SHALL have port busy, output, 1 bit: a transaction is in progress.
REQ-014 The module SHALL have port hpi_address, output, 2 bits: the HPI port select, where 00 = DATA, 01 = MAILBOX, 10 = ADDRESS and 11 = STATUS.
REQ-015 The module SHALL have port hpi_data_out, output, 16 bits: data toward the HPI pin interface.
REQ-016 The module SHALL have port hpi_data_in, input, 16 bits: registered HPI read data from the pin interface.
REQ-017 The module SHALL have ports hpi_r, hpi_w and hpi_cs, each an output of 1 bit: active-low read strobe, write strobe and chip select.

Function
REQ-018 A request SHALL be accepted on the rising edge where req_valid = 1 and req_ready = 1.
- At acceptance, req_we, req_addr and req_wdata are latched internally.
- Input changes after acceptance have no effect on the transaction.
REQ-019 req_ready SHALL be 1 only in state IDLE.
- busy = ~req_ready.
- A req_valid while busy is ignored and is not queued.
REQ-020 The FSM SHALL have states IDLE, A_SETUP, A_STB, A_REC, D_SETUP, D_STB, D_REC and RESP.
- IDLE -> A_SETUP on accept.
- Each timed state advances when its down-counter expires.
- A_REC -> D_SETUP.
- D_REC -> RESP.
- RESP -> IDLE unconditionally after one cycle.
REQ-021 The timed states SHALL use a single 4-bit down-counter, loaded with N-1 on state entry.
- N = SETUP_CYC, STROBE_CYC or RECOVER_CYC, according to the state.
- The state advances on the cycle in which the counter is 0.
REQ-022 In the address phase (A_*), the block SHALL drive hpi_address = 10 and hpi_data_out = the latched address.
REQ-023 In the data phase (D_*), the block SHALL drive hpi_address = 00.
- hpi_data_out = the latched write data for a write.
- hpi_data_out = 0 for a read.
REQ-024 Strobe timing SHALL be as follows.
- hpi_cs = 0 in *_SETUP and *_STB, and 1 elsewhere.
- hpi_w = 0 in A_STB, and in D_STB when writing.
- hpi_r = 0 in D_STB when reading.
- A strobe is 1 in every other state.
- hpi_r and hpi_w are never 0 in the same cycle.
REQ-025 For a read, rsp_rdata SHALL capture hpi_data_in on the last D_STB cycle (counter = 0).
- This allows for the 2-cycle register latency of the pin interface.
- rsp_rdata then holds that value until the next read captures.
REQ-026 For a write, rsp_rdata SHALL be left unchanged.
REQ-027 rsp_valid SHALL be 1 only in RESP.
- With acceptance at edge 0, rsp_valid = 1 in cycle 1 + 2*(SETUP_CYC + STROBE_CYC + RECOVER_CYC).
- With defaults, this is cycle 15.
REQ-028 A new request SHALL be acceptable in the cycle after RESP, so the default throughput is 1 transaction per 16 cycles.
REQ-029 All outputs SHALL be registered.
- Outputs have no combinational path from req_* to hpi_*.
- Outputs have no combinational path from hpi_data_in to rsp_*.

Reset
REQ-030 On a rising edge with Reset_N = 0, the state SHALL become IDLE and all outputs SHALL take their reset values.
- counter = 0.
- hpi_cs = hpi_r = hpi_w = 1.
- hpi_address = 00 and hpi_data_out = 0.
- rsp_valid = 0 and rsp_rdata = 0.
- req_ready = 1 and busy = 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction.
- Strobes deassert on the reset edge.
- No rsp_valid is produced for the abandoned request.
REQ-032 A request presented while Reset_N = 0 SHALL NOT be accepted.

Verification
REQ-033 A write with defaults (addr=0x1234, wdata=0xBEEF) SHALL produce the following.
- hpi_address = 10, data 0x1234, cs low cycles 1-5, w low cycles 2-5.
- Then hpi_address = 00, data 0xBEEF, cs low cycles 8-12, w low cycles 9-12.
- rsp_valid in cycle 15 only.
REQ-034 A read (addr=0x0400) with the pin-interface model returning 0xA5C3 SHALL produce the following.
- hpi_r low cycles 9-12, hpi_w high throughout the data phase.
- rsp_valid in cycle 15 with rsp_rdata = 0xA5C3.
REQ-035 A second req_valid asserted in cycles 1-15, with different addr/wdata, SHALL be ignored.
- The first transaction's pin values are unchanged.
- The second request is accepted at edge 16.
REQ-036 Reset_N driven low in cycle 10 of a write SHALL produce the following.
- From cycle 11: cs, w and r are all 1, busy = 0, and rsp_valid never pulses.
- The next request completes normally.
REQ-037 With SETUP_CYC=2, STROBE_CYC=3, RECOVER_CYC=1, any request SHALL complete with rsp_valid in cycle 13.
REQ-038 Back-to-back requests with req_valid held high SHALL be accepted at edges 0 and 16, and a checker SHALL confirm that r and w are never both low.
